// File: rtl/seg7_digit_counter.sv
// Prescaled single-digit BCD up/down counter with parallel load and a registered
// seven-segment decode; seg is decoded from the next-state digit so it never lags digit.
module seg7_digit_counter #(
    parameter int unsigned PRESCALE = 10000000,
    parameter int unsigned CNT_W    = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] digit,
    output logic [6:0] seg,
    output logic       dp,
    output logic       tick,
    output logic       carry
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       digit_q, digit_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             tick_q, tick_d;
    logic             carry_q, carry_d;
    logic             step;
    logic             wrap;

    function automatic logic [6:0] seg_of(input logic [3:0] val);
        logic [6:0] pat;
        case (val)
            4'd0:    pat = 7'h3F;
            4'd1:    pat = 7'h06;
            4'd2:    pat = 7'h5B;
            4'd3:    pat = 7'h4F;
            4'd4:    pat = 7'h66;
            4'd5:    pat = 7'h6D;
            4'd6:    pat = 7'h7D;
            4'd7:    pat = 7'h07;
            4'd8:    pat = 7'h7F;
            4'd9:    pat = 7'h6F;
            default: pat = 7'h00;
        endcase
        return pat;
    endfunction

    // A load suppresses the step that would otherwise happen on the same edge.
    always_comb begin
        step = en && (cnt_q == CNT_MAX) && !load;
        wrap = up ? (digit_q == 4'd9) : (digit_q == 4'd0);
    end

    always_comb begin
        cnt_d   = cnt_q;
        digit_d = digit_q;
        dp_d    = dp_q;
        tick_d  = 1'b0;
        carry_d = 1'b0;
        if (load) begin
            cnt_d   = '0;
            digit_d = (load_val <= 4'd9) ? load_val : 4'd0;
        end else if (en) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        if (step) begin
            tick_d  = 1'b1;
            carry_d = wrap;
            dp_d    = ~dp_q;
            if (up) begin
                digit_d = wrap ? 4'd0 : digit_q + 4'd1;
            end else begin
                digit_d = wrap ? 4'd9 : digit_q - 4'd1;
            end
        end
        seg_d = seg_of(digit_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            digit_q <= 4'd0;
            seg_q   <= 7'h3F;
            dp_q    <= 1'b0;
            tick_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            tick_q  <= tick_d;
            carry_q <= carry_d;
        end
    end

    assign digit = digit_q;
    assign seg   = seg_q;
    assign dp    = dp_q;
    assign tick  = tick_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_seg7_digit_counter.sv
// Bench for seg7_digit_counter (PRESCALE=4): directed vector table, corner sequences,
// and random stimulus checked against a modular-arithmetic reference model.
module tb_seg7_digit_counter;

    localparam int P = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] digit;
    logic [6:0] seg;
    logic       dp;
    logic       tick;
    logic       carry;

    seg7_digit_counter #(.PRESCALE(P), .CNT_W(24)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .digit(digit), .seg(seg), .dp(dp), .tick(tick), .carry(carry)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // reference model: enabled-cycle count and digit kept as plain integers
    int m_cnt = 0;
    int m_digit = 0;
    int m_dp = 0;
    int m_tick = 0;
    int m_carry = 0;

    typedef struct {
        logic       r, e, u, l;
        logic [3:0] lv;
        logic [3:0] x_digit;
        logic [6:0] x_seg;
        logic       x_tick, x_carry, x_dp;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic r, e, u, l, input logic [3:0] lv,
                                input logic [3:0] xd, input logic [6:0] xs,
                                input logic xt, xc, xp);
        vec_t v;
        v.r = r; v.e = e; v.u = u; v.l = l; v.lv = lv;
        v.x_digit = xd; v.x_seg = xs; v.x_tick = xt; v.x_carry = xc; v.x_dp = xp;
        return v;
    endfunction

    task automatic check(input string nm, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    task automatic model_update(input logic r, e, u, l, input logic [3:0] lv);
        if (r) begin
            m_cnt = 0; m_digit = 0; m_dp = 0; m_tick = 0; m_carry = 0;
        end else if (l) begin
            m_cnt = 0;
            m_digit = (int'(lv) <= 9) ? int'(lv) : 0;
            m_tick = 0; m_carry = 0;
        end else if (e) begin
            m_cnt = m_cnt + 1;
            m_tick = 0; m_carry = 0;
            if (m_cnt == P) begin
                m_cnt = 0;
                m_tick = 1;
                m_dp = 1 - m_dp;
                if (u) begin
                    m_carry = (m_digit == 9) ? 1 : 0;
                    m_digit = (m_digit + 1) % 10;
                end else begin
                    m_carry = (m_digit == 0) ? 1 : 0;
                    m_digit = (m_digit + 9) % 10;
                end
            end
        end else begin
            m_tick = 0; m_carry = 0;
        end
    endtask

    task automatic check_model();
        check("model_digit", int'(digit), m_digit);
        check("model_seg",   int'(seg),   int'(seg_tab[m_digit]));
        check("model_tick",  int'(tick),  m_tick);
        check("model_carry", int'(carry), m_carry);
        check("model_dp",    int'(dp),    m_dp);
    endtask

    task automatic cyc(input logic r, e, u, l, input logic [3:0] lv);
        rst = r; en = e; up = u; load = l; load_val = lv;
        @(posedge clk);
        #1;
        model_update(r, e, u, l, lv);
        check_model();
    endtask

    initial begin
        int ticks;
        int carries;
        int found;

        // directed vector table (hand-derived expectations)
        vq.push_back(mk(1,0,0,0,4'd0,  4'd0, 7'h3F, 0,0,0));
        vq.push_back(mk(0,1,1,0,4'd0,  4'd0, 7'h3F, 0,0,0));
        vq.push_back(mk(0,1,1,0,4'd0,  4'd0, 7'h3F, 0,0,0));
        vq.push_back(mk(0,1,1,0,4'd0,  4'd0, 7'h3F, 0,0,0));
        vq.push_back(mk(0,1,1,0,4'd0,  4'd1, 7'h06, 1,0,1));
        vq.push_back(mk(0,0,1,0,4'd0,  4'd1, 7'h06, 0,0,1));
        vq.push_back(mk(0,1,1,0,4'd0,  4'd1, 7'h06, 0,0,1));
        vq.push_back(mk(0,0,0,1,4'd12, 4'd0, 7'h3F, 0,0,1));
        vq.push_back(mk(0,1,0,0,4'd0,  4'd0, 7'h3F, 0,0,1));
        vq.push_back(mk(0,1,0,0,4'd0,  4'd0, 7'h3F, 0,0,1));
        vq.push_back(mk(0,1,0,0,4'd0,  4'd0, 7'h3F, 0,0,1));
        vq.push_back(mk(0,1,0,0,4'd0,  4'd9, 7'h6F, 1,1,0));
        vq.push_back(mk(0,1,0,0,4'd0,  4'd9, 7'h6F, 0,0,0));
        vq.push_back(mk(0,1,0,0,4'd0,  4'd9, 7'h6F, 0,0,0));
        vq.push_back(mk(0,1,0,0,4'd0,  4'd9, 7'h6F, 0,0,0));
        vq.push_back(mk(0,1,0,0,4'd0,  4'd8, 7'h7F, 1,0,1));
        vq.push_back(mk(0,1,1,0,4'd0,  4'd8, 7'h7F, 0,0,1));
        vq.push_back(mk(0,1,1,0,4'd0,  4'd8, 7'h7F, 0,0,1));
        vq.push_back(mk(0,1,1,0,4'd0,  4'd8, 7'h7F, 0,0,1));
        vq.push_back(mk(0,1,1,1,4'd7,  4'd7, 7'h07, 0,0,1));
        vq.push_back(mk(0,1,1,0,4'd0,  4'd7, 7'h07, 0,0,1));
        vq.push_back(mk(0,1,1,0,4'd0,  4'd7, 7'h07, 0,0,1));
        vq.push_back(mk(0,1,1,0,4'd0,  4'd7, 7'h07, 0,0,1));
        vq.push_back(mk(0,1,1,0,4'd0,  4'd8, 7'h7F, 1,0,0));
        vq.push_back(mk(0,1,1,0,4'd0,  4'd8, 7'h7F, 0,0,0));
        vq.push_back(mk(0,1,1,0,4'd0,  4'd8, 7'h7F, 0,0,0));
        vq.push_back(mk(0,1,1,0,4'd0,  4'd8, 7'h7F, 0,0,0));
        vq.push_back(mk(0,1,1,0,4'd0,  4'd9, 7'h6F, 1,0,1));
        vq.push_back(mk(0,1,1,0,4'd0,  4'd9, 7'h6F, 0,0,1));
        vq.push_back(mk(0,1,1,0,4'd0,  4'd9, 7'h6F, 0,0,1));
        vq.push_back(mk(0,1,1,0,4'd0,  4'd9, 7'h6F, 0,0,1));
        vq.push_back(mk(0,1,1,0,4'd0,  4'd0, 7'h3F, 1,1,0));
        vq.push_back(mk(0,1,1,0,4'd0,  4'd0, 7'h3F, 0,0,0));
        vq.push_back(mk(1,1,1,1,4'd7,  4'd0, 7'h3F, 0,0,0));

        foreach (vq[i]) begin
            cyc(vq[i].r, vq[i].e, vq[i].u, vq[i].l, vq[i].lv);
            check($sformatf("vec%0d_digit", i), int'(digit), int'(vq[i].x_digit));
            check($sformatf("vec%0d_seg", i),   int'(seg),   int'(vq[i].x_seg));
            check($sformatf("vec%0d_tick", i),  int'(tick),  int'(vq[i].x_tick));
            check($sformatf("vec%0d_carry", i), int'(carry), int'(vq[i].x_carry));
            check($sformatf("vec%0d_dp", i),    int'(dp),    int'(vq[i].x_dp));
        end

        // 40-cycle up count from reset
        cyc(1, 0, 0, 0, 4'd0);
        ticks = 0;
        carries = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc(0, 1, 1, 0, 4'd0);
            check("upcnt_tick_phase", int'(tick), (i % 4 == 0) ? 1 : 0);
            ticks += int'(tick);
            carries += int'(carry);
            if (carry) check("upcnt_carry_at", i, 40);
        end
        check("upcnt_ticks", ticks, 10);
        check("upcnt_carries", carries, 1);
        check("upcnt_final_digit", int'(digit), 0);
        check("upcnt_final_dp", int'(dp), 0);

        // freeze with en=0 at cnt=2, then resume
        cyc(1, 0, 0, 0, 4'd0);
        cyc(0, 1, 1, 0, 4'd0);
        cyc(0, 1, 1, 0, 4'd0);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 1, 0, 4'd0);
            check("freeze_tick", int'(tick), 0);
            check("freeze_digit", int'(digit), 0);
        end
        found = 0;
        for (int k = 1; k <= 8 && found == 0; k++) begin
            cyc(0, 1, 1, 0, 4'd0);
            if (tick) found = k;
        end
        check("resume_tick_delay", found, 2);
        check("resume_digit", int'(digit), 1);

        // reset beats a coincident load and step at digit 5
        cyc(1, 0, 0, 0, 4'd0);
        for (int i = 0; i < 23; i++) cyc(0, 1, 1, 0, 4'd0);
        check("pre_rst_digit", int'(digit), 5);
        cyc(1, 1, 1, 1, 4'd7);
        check("rst_digit", int'(digit), 0);
        check("rst_seg", int'(seg), 'h3F);
        check("rst_dp", int'(dp), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_carry", int'(carry), 0);

        // randomized stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
                4'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_digit_counter.md
Name: seg7_digit_counter

Overview:
- Upstream stage for the top-level seven-segment output.
- Generates a prescaled tick and counts one BCD digit (0–9) up or down, with parallel load.
- Outputs a registered 7-segment pattern that the top level drives straight onto uo_out[6:0], plus a decimal point for uo_out[7].
- Replaces the constant "0" pattern with a live counting digit.

Parameters:
- PRESCALE, 10000000: clk cycles per count step (1 Hz at 10 MHz). Legal range 1 .. 2^24-1.
- CNT_W, 24: prescaler width. Must satisfy 2^CNT_W > PRESCALE-1.

Ports:
- clk, input, 1: system clock, all state on rising edge.
- rst, input, 1: reset.
- en, input, 1: count enable. 0 freezes the prescaler and digit.
- up, input, 1: direction. 1 = increment, 0 = decrement.
- load, input, 1: single-cycle strobe to load load_val.
- load_val, input, 4: value to load.
- digit, output, 4: current BCD value.
- seg, output, 7: segment pattern. bit0=a … bit6=g, 1 = segment lit.
- dp, output, 1: decimal point. Toggles on each step.
- tick, output, 1: one-cycle pulse on each count step.
- carry, output, 1: one-cycle pulse on wrap (9->0 up, 0->9 down).

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst=1 at an edge) overrides all other inputs, including mid-count and during load. Values after reset:
  - prescaler = 0
  - digit = 0
  - seg = 7'b0111111
  - dp = 0
  - tick = 0
  - carry = 0
- All outputs are registered. No combinational path from any input to any output.
- Prescaler:
  - With en=1 and cnt < PRESCALE-1: cnt <= cnt+1.
  - With en=1 and cnt == PRESCALE-1: cnt <= 0 and a step occurs at this edge.
  - With en=0: cnt holds, and no step occurs.
  - PRESCALE=1: a step occurs on every enabled cycle.
- Step (at the edge where the step condition holds):
  - tick <= 1
  - dp <= ~dp
  - Digit update:
    - up=1, digit < 9: digit <= digit+1.
    - up=1, digit == 9: digit <= 0 and carry <= 1.
    - up=0, digit > 0: digit <= digit-1.
    - up=0, digit == 0: digit <= 9 and carry <= 1.
  - On every non-step edge, tick <= 0 and carry <= 0. Both are therefore exactly one cycle wide.
- Load (load=1, rst=0):
  - Has priority over a coincident step. Load wins; no tick, carry or dp toggle that cycle.
  - digit <= load_val if load_val <= 9. Values 10–15 load 0.
  - cnt <= 0, so the next step is PRESCALE enabled cycles later.
  - Load acts regardless of en.
- seg decode is registered from the next-state digit, so seg always matches digit in the same cycle (zero extra latency). Encoding, digit:value:
  - 0:0x3F, 1:0x06, 2:0x5B, 3:0x4F, 4:0x66
  - 5:0x6D, 6:0x7D, 7:0x07, 8:0x7F, 9:0x6F
- Direction change (up toggled) takes effect at the next step. The prescaler is not disturbed.
- Illegal digit states (10–15) are unreachable. If the decoder sees one, it outputs 0x00.

Test Plan (all with PRESCALE=4):
- Reset then en=1, up=1 for 40 cycles:
  - tick pulses every 4th cycle.
  - digit steps 0,1,…,9,0.
  - seg goes 0x3F,0x06,…,0x6F,0x3F.
  - carry pulses once, coincident with the 9->0 step.
  - dp toggles at each tick.
- up=0 from digit=0, en=1:
  - First step gives digit=9, seg=0x6F, carry=1 for one cycle.
  - Next step gives digit=8, carry=0.
- en=0 for 10 cycles mid-count (cnt=2):
  - digit, dp and cnt are frozen; no tick.
  - After en=1 returns, the next tick arrives 2 enabled cycles later.
- Load tests:
  - load=1, load_val=7, asserted on a step cycle: digit=7, seg=0x07, tick=0, carry=0. Next tick occurs exactly 4 enabled cycles later.
  - load_val=12: digit=0, seg=0x3F.
- rst=1 asserted simultaneously with load=1 and a step, at digit=5: all outputs return to their reset values (digit=0, seg=0x3F, dp=0, tick=0, carry=0).
